// File: rtl/pong_pkg.sv
// pong_pkg: geometry and game-state definitions shared by the pong blocks
// (game controller, compositor, paddle logic). Geometry constants are in
// raster-counter coordinates, where 0 is the start of the sync pulse. They
// are 11 bits wide so that "position minus speed" can never wrap.
package pong_pkg;

  localparam logic [10:0] H          = 11'd640;
  localparam logic [10:0] V          = 11'd480;
  localparam logic [10:0] X0         = 11'd144;
  localparam logic [10:0] Y0         = 11'd35;
  localparam logic [10:0] BORDER     = 11'd8;
  localparam logic [10:0] BALL_SIZE  = 11'd16;
  localparam logic [10:0] BALL_SPEED = 11'd4;
  localparam logic [10:0] PADDLE_W   = 11'd8;
  localparam logic [10:0] PADDLE_H   = 11'd64;
  localparam logic [10:0] PADDLE_XL  = 11'd160;
  localparam logic [10:0] PADDLE_XR  = 11'd760;

  localparam logic [5:0]  SERVE_FRAMES = 6'd60;
  localparam logic [3:0]  WIN_SCORE    = 4'd9;

  // Derived playfield limits for the ball's top-left corner
  localparam logic [10:0] XMIN = X0;
  localparam logic [10:0] XMAX = X0 + H - BALL_SIZE;
  localparam logic [10:0] YMIN = Y0 + BORDER;
  localparam logic [10:0] YMAX = Y0 + V - BORDER - BALL_SIZE;
  localparam logic [10:0] CX   = X0 + ((H - BALL_SIZE) >> 1);
  localparam logic [10:0] CY   = Y0 + ((V - BALL_SIZE) >> 1);

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_SERVE = 2'd1,
    GS_PLAY  = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  // Vertical overlap between the ball and a paddle, both given by top line
  function automatic logic paddle_overlap(input logic [10:0] ball_top,
                                          input logic [10:0] paddle_top);
    return ((ball_top + BALL_SIZE) > paddle_top) &&
           (ball_top < (paddle_top + PADDLE_H));
  endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: brings the VGA vertical sync into the pixel clock domain
// through two flops and emits a one-cycle frame_tick on its rising edge.
// Ports:
//   pixel_clock  in   pixel clock
//   reset_n      in   asynchronous, active-low reset
//   vga_vs       in   vertical sync, asynchronous to pixel_clock
//   frame_tick   out  one-cycle strobe per frame (registered)
module pong_frame_tick (
  input  logic pixel_clock,
  input  logic reset_n,
  input  logic vga_vs,
  output logic frame_tick
);

  logic vs_meta_reg;
  logic vs_sync_reg;
  logic vs_prev_reg;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta_reg <= 1'b0;
      vs_sync_reg <= 1'b0;
      vs_prev_reg <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      vs_meta_reg <= vga_vs;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_sync_reg;
      frame_tick  <= vs_sync_reg & ~vs_prev_reg;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for pong. Owns ball position/direction,
// paddle and wall bounces, scoring and the IDLE/SERVE/PLAY/OVER flow.
// Advances once per frame_tick; start is honoured on any cycle in IDLE/OVER.
// Ports:
//   pixel_clock   in   pixel clock
//   reset_n       in   asynchronous, active-low reset
//   frame_tick    in   one-cycle strobe per frame
//   start         in   start button (synchronised)
//   paddle_l_y    in   top line of left paddle
//   paddle_r_y    in   top line of right paddle
//   ball_x/ball_y out  ball top-left corner
//   ball_visible  out  ball is drawn
//   score_l/_r    out  player scores
//   game_state    out  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
//   winner        out  0 left, 1 right (valid in OVER)
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_visible,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       winner
);

  localparam logic [10:0] PADDLE_L_FACE = PADDLE_XL + PADDLE_W;
  localparam logic [10:0] PADDLE_R_STOP = PADDLE_XR - BALL_SIZE;
  localparam logic [9:0]  CX10 = CX[9:0];
  localparam logic [9:0]  CY10 = CY[9:0];

  game_state_t state_reg;
  logic        dir_x_reg;  // 1 = moving right
  logic        dir_y_reg;  // 1 = moving down
  logic [5:0]  serve_cnt_reg;

  logic [10:0] x_cur, y_cur, x_next, y_next;
  logic        wall_top, wall_bot;
  logic        hit_l, hit_r, miss_l, miss_r;
  logic [3:0]  score_l_inc, score_r_inc;

  assign x_cur  = {1'b0, ball_x};
  assign y_cur  = {1'b0, ball_y};
  assign x_next = dir_x_reg ? (x_cur + BALL_SPEED) : (x_cur - BALL_SPEED);
  assign y_next = dir_y_reg ? (y_cur + BALL_SPEED) : (y_cur - BALL_SPEED);

  assign wall_top = (y_next < YMIN);
  assign wall_bot = (y_next > YMAX);

  // A paddle only catches a ball that is crossing its face this frame;
  // the overlap test uses the pre-move ball_y.
  assign hit_l = !dir_x_reg && (x_next < PADDLE_L_FACE) && (x_cur >= PADDLE_L_FACE)
               && paddle_overlap(y_cur, {1'b0, paddle_l_y});
  assign hit_r = dir_x_reg && ((x_next + BALL_SIZE) > PADDLE_XR)
               && ((x_cur + BALL_SIZE) <= PADDLE_XR)
               && paddle_overlap(y_cur, {1'b0, paddle_r_y});
  assign miss_l = !dir_x_reg && (x_next < XMIN);
  assign miss_r = dir_x_reg && (x_next > XMAX);

  assign score_l_inc = score_l + 4'd1;
  assign score_r_inc = score_r + 4'd1;

  assign game_state = state_reg;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= GS_IDLE;
      ball_x        <= CX10;
      ball_y        <= CY10;
      dir_x_reg     <= 1'b1;
      dir_y_reg     <= 1'b1;
      score_l       <= 4'd0;
      score_r       <= 4'd0;
      winner        <= 1'b0;
      ball_visible  <= 1'b0;
      serve_cnt_reg <= 6'd0;
    end else begin
      case (state_reg)
        // start takes priority over frame_tick here: no movement that cycle
        GS_IDLE, GS_OVER: begin
          if (start) begin
            state_reg     <= GS_SERVE;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            ball_x        <= CX10;
            ball_y        <= CY10;
            ball_visible  <= 1'b1;
            serve_cnt_reg <= SERVE_FRAMES;
          end
        end

        GS_SERVE: begin
          if (frame_tick) begin
            serve_cnt_reg <= serve_cnt_reg - 6'd1;
            if (serve_cnt_reg == 6'd1) state_reg <= GS_PLAY;
          end
        end

        GS_PLAY: begin
          if (frame_tick) begin
            if (wall_top) begin
              ball_y    <= YMIN[9:0];
              dir_y_reg <= 1'b1;
            end else if (wall_bot) begin
              ball_y    <= YMAX[9:0];
              dir_y_reg <= 1'b0;
            end else begin
              ball_y    <= y_next[9:0];
            end

            if (hit_l) begin
              ball_x    <= PADDLE_L_FACE[9:0];
              dir_x_reg <= 1'b1;
            end else if (hit_r) begin
              ball_x    <= PADDLE_R_STOP[9:0];
              dir_x_reg <= 1'b0;
            end else if (miss_l || miss_r) begin
              // Recentre (overrides the wall result) and serve toward the
              // player who conceded.
              ball_x    <= CX10;
              ball_y    <= CY10;
              dir_x_reg <= miss_r;
              if (miss_l) score_r <= score_r_inc;
              else        score_l <= score_l_inc;
              if ((miss_l && score_r_inc == WIN_SCORE) ||
                  (miss_r && score_l_inc == WIN_SCORE)) begin
                state_reg    <= GS_OVER;
                winner       <= miss_l;
                ball_visible <= 1'b0;
              end else begin
                state_reg     <= GS_SERVE;
                serve_cnt_reg <= SERVE_FRAMES;
              end
            end else begin
              ball_x <= x_next[9:0];
            end
          end
        end

        default: state_reg <= GS_IDLE;
      endcase
    end
  end

endmodule
